// File: rtl/fram_i2c_pkg.sv
// Shared types and constants for the FRAM-style I2C target.
package fram_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEV_ADDR,
    ACK_DEV,
    WORD_ADDR,
    ACK_WORD,
    WRITE_BYTE,
    READ_BYTE,
    READ_ACK
  } target_state_t;

  localparam logic [3:0] DEV_TYPE = 4'b1010;

  // True when the first seven bits of an address byte select this device.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [2:0] pins);
    return addr_byte[7:1] == {DEV_TYPE, pins};
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one I2C line.
// The level changes only after FILTER_LEN identical synchronised samples.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Lines idle high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta <= pad;
      sync <= meta;
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync;
        rise  <= sync;
        fall  <= ~sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fram_i2c_target.sv
// FM24CLxx-style FRAM I2C target: 8-bit word address, byte-wide memory.
// FRAM_I2C_TARGET_WP_EN adds a wp input that blocks memory writes.
module fram_i2c_target
  import fram_i2c_pkg::*;
#(
  parameter logic [2:0] DEV_PINS   = 3'b000,
  parameter int         DEPTH      = 256,
  parameter int         FILTER_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl_i,
  input  logic                     sda_i,
`ifdef FRAM_I2C_TARGET_WP_EN
  input  logic                     wp,
`endif
  output logic                     sda_o,
  output logic                     sda_t,
  output logic                     busy,
  output logic                     wr_pulse,
  output target_state_t            state_dbg,
  output logic [$clog2(DEPTH)-1:0] ptr_dbg
);

  localparam int AW = $clog2(DEPTH);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk  (clk),
    .rst  (rst),
    .pad  (scl_i),
    .level(scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk  (clk),
    .rst  (rst),
    .pad  (sda_i),
    .level(sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  target_state_t state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [AW-1:0] ptr;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    mem_rdata;
  logic          start_cond;
  logic          stop_cond;
  logic          byte_done;
  logic          wp_ok;
  logic          commit;

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  // Falling edge after the eighth bit; bus conditions take priority over it.
  assign byte_done = scl_fall & (bit_cnt == 4'd8) & ~start_cond & ~stop_cond;

`ifdef FRAM_I2C_TARGET_WP_EN
  assign wp_ok = ~wp;
`else
  assign wp_ok = 1'b1;
`endif

  assign commit = ~rst & byte_done & (state == WRITE_BYTE) & wp_ok;

  // mem[ptr] is read every cycle, so the data is ready well before any
  // falling edge that needs to drive it.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[ptr] <= shreg;
    end
    mem_rdata <= mem[ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      sda_t    <= 1'b1;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= commit;
      if (start_cond) begin
        state   <= DEV_ADDR;
        bit_cnt <= '0;
        sda_t   <= 1'b1;
      end else if (stop_cond) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_t   <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_t <= 1'b1;
          end

          DEV_ADDR, WORD_ADDR, WRITE_BYTE: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              bit_cnt <= '0;
              if (state == DEV_ADDR) begin
                if (addr_match(shreg, DEV_PINS)) begin
                  state <= ACK_DEV;
                  sda_t <= 1'b0;
                  busy  <= 1'b1;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else if (state == WORD_ADDR) begin
                ptr   <= shreg[AW-1:0];
                state <= ACK_WORD;
                sda_t <= 1'b0;
              end else begin
                // Data byte: pointer advances even when the write is blocked.
                ptr   <= ptr + AW'(1);
                state <= ACK_WORD;
                sda_t <= 1'b0;
              end
            end
          end

          ACK_DEV: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (shreg[0]) begin
                state <= READ_BYTE;
                shreg <= mem_rdata;
                sda_t <= mem_rdata[7];
              end else begin
                state <= WORD_ADDR;
                sda_t <= 1'b1;
              end
            end
          end

          ACK_WORD: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              state   <= WRITE_BYTE;
              sda_t   <= 1'b1;
            end
          end

          READ_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_t   <= 1'b1;
                ptr     <= ptr + AW'(1);
                bit_cnt <= '0;
                state   <= READ_ACK;
              end else begin
                shreg <= {shreg[6:0], 1'b0};
                sda_t <= shreg[6];
              end
            end
          end

          READ_ACK: begin
            // bit_cnt marks a master ACK seen on the ninth rising edge.
            if (scl_rise) begin
              if (sda_lvl) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                bit_cnt <= 4'd1;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt <= '0;
              state   <= READ_BYTE;
              shreg   <= mem_rdata;
              sda_t   <= mem_rdata[7];
            end
          end

          default: begin
            state <= IDLE;
            sda_t <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sda_o     = 1'b0;
  assign state_dbg = state;
  assign ptr_dbg   = ptr;

endmodule

// File: tb/tb_fram_i2c_target.sv
// Bench for fram_i2c_target: bit-banged I2C master, memory/pointer model,
// and a compare process watching strobes, read data and SDA timing.
module tb_fram_i2c_target;
  import fram_i2c_pkg::*;

  localparam int         Q      = 16;
  localparam logic [7:0] ADDR_W = {DEV_TYPE, 3'b000, 1'b0};
  localparam logic [7:0] ADDR_R = {DEV_TYPE, 3'b000, 1'b1};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_bus;
  logic          sda_o, sda_t, busy, wr_pulse;
  target_state_t state_dbg;
  logic [7:0]    ptr_dbg;
`ifdef FRAM_I2C_TARGET_WP_EN
  logic          wp = 1'b0;
`endif

  // Open-drain wired-AND of master and target.
  assign sda_bus = sda_m & (sda_t | sda_o);

  fram_i2c_target #(.DEV_PINS(3'b000), .DEPTH(256), .FILTER_LEN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
`ifdef FRAM_I2C_TARGET_WP_EN
    .wp       (wp),
`endif
    .sda_o    (sda_o),
    .sda_t    (sda_t),
    .busy     (busy),
    .wr_pulse (wr_pulse),
    .state_dbg(state_dbg),
    .ptr_dbg  (ptr_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model + scoreboard ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_wr_pulse = 0;
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr = 8'h00;
  bit         wp_model = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];
  logic [7:0] exp_wr_q[$];
  logic [7:0] rd_log[$];
  bit         busy_low_win = 1'b0;
  logic       sda_t_prev = 1'b1;
  logic [7:0] wr_a, wr_exp, rd_a, rd_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sda_t_prev = 1'b1;
    end else begin
      if (wr_pulse) begin
        n_wr_pulse++;
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_pulse: strobe seen with ptr 0x%0h, required no strobe", ptr_dbg);
        end else begin
          wr_a   = exp_wr_q.pop_front();
          wr_exp = wr_a + 8'd1;
          check("wr_ptr", ptr_dbg, wr_exp);
        end
      end
      if (exp_q.size() != 0 && act_q.size() != 0) begin
        rd_e = exp_q.pop_front();
        rd_a = act_q.pop_front();
        check("rd_byte", rd_a, rd_e);
      end
      if (sda_t !== sda_t_prev) begin
        check("sda_t_moves_with_scl_low", scl_m, 0);
        if (sda_t === 1'b0) check("sda_o_low", sda_o, 0);
      end
      if (busy_low_win) check("busy_nomatch", busy, 0);
      sda_t_prev = sda_t;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b0; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_bus;  wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack);
  endtask

  // Write n bytes (packed MSB-first in data) starting at word.
  task automatic tx_write(input logic [7:0] word, input int n, input logic [31:0] data);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    write_byte(ADDR_W, ack);
    check("wr_addr_ack", ack, 0);
    check("wr_busy_after_match", busy, 1);
    write_byte(word, ack);
    check("wr_word_ack", ack, 0);
    model_ptr = word;
    for (int i = 0; i < n; i++) begin
      d = data[31-8*i -: 8];
      if (!wp_model) begin
        exp_wr_q.push_back(model_ptr);
        model_mem[model_ptr] = d;
      end
      model_ptr++;
      write_byte(d, ack);
      check("wr_data_ack", ack, 0);
    end
    i2c_stop();
    check("wr_busy_after_stop", busy, 0);
    check("wr_strobes_all_seen", exp_wr_q.size(), 0);
    check("wr_ptr_after_stop", ptr_dbg, model_ptr);
  endtask

  // Random read (random=1) or current-address read of n bytes, NACK on last.
  task automatic tx_read(input bit random, input logic [7:0] word, input int n);
    logic       ack;
    logic [7:0] d;
    rd_log.delete();
    if (random) begin
      i2c_start();
      write_byte(ADDR_W, ack);
      check("rd_addr_w_ack", ack, 0);
      write_byte(word, ack);
      check("rd_word_ack", ack, 0);
      model_ptr = word;
    end
    i2c_start();
    write_byte(ADDR_R, ack);
    check("rd_addr_r_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[model_ptr]);
      model_ptr++;
      read_byte(i == n - 1, d);
      act_q.push_back(d);
      rd_log.push_back(d);
    end
    check("nack_busy", busy, 0);
    check("nack_state", state_dbg, IDLE);
    check("nack_ptr", ptr_dbg, model_ptr);
    i2c_stop();
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic ack;
    int   pulses_before;

    wait_clk(5);
    rst = 1'b0;
    check("rst_sda_t", sda_t, 1);
    check("rst_sda_o", sda_o, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_state", state_dbg, IDLE);
    check("rst_ptr", ptr_dbg, 0);
    wait_clk(10);

    // Preload bytes used by later tests.
    tx_write(8'h01, 1, 32'h7700_0000);
    tx_write(8'h30, 1, 32'h4200_0000);

    // Single write then random read of the same word.
    pulses_before = n_wr_pulse;
    tx_write(8'h04, 1, 32'hA500_0000);
    check("single_wr_pulse_count", n_wr_pulse - pulses_before, 1);
    tx_read(1'b1, 8'h04, 1);
    check("rand_read_a5", rd_log[0], 8'hA5);

    // Wrong pin address: no ACK, nothing committed, busy never rises.
    pulses_before = n_wr_pulse;
    busy_low_win = 1'b1;
    i2c_start();
    write_byte(8'hA2, ack);
    check("nomatch_nack", ack, 1);
    i2c_stop();
    busy_low_win = 1'b0;
    check("nomatch_no_pulse", n_wr_pulse - pulses_before, 0);

    // Sequential write across the top of memory, then current-address read.
    tx_write(8'hFE, 3, 32'h1122_3300);
    check("wrap_ptr", ptr_dbg, 8'h01);
    tx_read(1'b0, 8'h00, 1);
    check("cur_read_mem01", rd_log[0], 8'h77);
    tx_read(1'b1, 8'hFE, 3);
    check("wrap_mem_fe", rd_log[0], 8'h11);
    check("wrap_mem_ff", rd_log[1], 8'h22);
    check("wrap_mem_00", rd_log[2], 8'h33);

    // Sequential read of four bytes.
    tx_write(8'h10, 4, 32'hDEAD_BEEF);
    tx_read(1'b1, 8'h10, 4);
    check("seq_rd_0", rd_log[0], 8'hDE);
    check("seq_rd_1", rd_log[1], 8'hAD);
    check("seq_rd_2", rd_log[2], 8'hBE);
    check("seq_rd_3", rd_log[3], 8'hEF);
    check("seq_rd_ptr", ptr_dbg, 8'h14);

    // START after four bits of a data byte: that byte must be dropped.
    pulses_before = n_wr_pulse;
    i2c_start();
    write_byte(ADDR_W, ack);
    check("inj_addr_ack", ack, 0);
    write_byte(8'h30, ack);
    check("inj_word_ack", ack, 0);
    model_ptr = 8'h30;
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b0); write_bit(1'b1);
    tx_read(1'b1, 8'h30, 1);
    check("inj_no_pulse", n_wr_pulse - pulses_before, 0);
    check("inj_mem_kept", rd_log[0], 8'h42);

`ifdef FRAM_I2C_TARGET_WP_EN
    // Write-protect: ACKed but not stored.
    tx_write(8'h20, 1, 32'h3C00_0000);
    wp = 1'b1;
    wp_model = 1'b1;
    pulses_before = n_wr_pulse;
    tx_write(8'h20, 1, 32'h5A00_0000);
    check("wp_no_pulse", n_wr_pulse - pulses_before, 0);
    wp = 1'b0;
    wp_model = 1'b0;
    tx_read(1'b1, 8'h20, 1);
    check("wp_mem_kept", rd_log[0], 8'h3C);
`endif

    // Reset while the target is driving a 0 bit of read data.
    i2c_start();
    write_byte(ADDR_W, ack);
    write_byte(8'h01, ack);
    i2c_start();
    write_byte(ADDR_R, ack);
    check("mid_read_addr_ack", ack, 0);
    check("mid_read_driving", sda_t, 0);
    rst = 1'b1;
    wait_clk(1);
    check("mid_read_rst_release", sda_t, 1);
    check("mid_read_rst_busy", busy, 0);
    wait_clk(3);
    rst = 1'b0;
    model_ptr = 8'h00;
    i2c_stop();
    tx_read(1'b0, 8'h00, 1);
    check("post_rst_cur_read", rd_log[0], 8'h33);

    wait_clk(20);
    check("exp_q_drained", exp_q.size(), 0);
    check("act_q_drained", act_q.size(), 0);
    check("wr_q_drained", exp_wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
